line_fill_ctrl: RTL and testbench



---
 rtl/fill_pkg.sv | 17 +
 rtl/wrap_counter.sv | 24 ++
 rtl/line_fill_ctrl.sv | 155 +++++++++++++++
 tb/tb_line_fill_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fill_pkg.sv
// Shared types for the cache-line fill sequencer.
package fill_pkg;

    // Fill sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } t_fill_state;

    // Number of address bits needed to select a byte within a word
    function automatic int unsigned byte_offset_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Loadable up-counter that wraps modulo 2^WIDTH; tracks the current line word offset.
module wrap_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Load has priority over increment; natural overflow gives the wrap
    always_ff @(posedge clk) begin
        if (arst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/line_fill_ctrl.sv
// Cache-line fill sequencer: one single-word read at a time, critical word first
// with wrap-around, assembling returned words into a line buffer.
module line_fill_ctrl
    import fill_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned WORDS_PER_LINE = 16
) (
    input  logic                                     clk,
    input  logic                                     arst,
    input  logic                                     i_fill_req,
    input  logic [AXI_ADDR_WIDTH-1:0]                i_fill_addr,
    output logic                                     o_fill_busy,
    output logic                                     o_fill_done,
    output logic                                     o_fill_fault,
    output logic [WORDS_PER_LINE*AXI_DATA_WIDTH-1:0] o_line,
    output logic [AXI_ADDR_WIDTH-1:0]                o_line_addr,
    output logic                                     o_crit_valid,
    output logic [AXI_DATA_WIDTH-1:0]                o_crit_word,
    output logic [AXI_ADDR_WIDTH-1:0]                o_rd_addr,
    output logic                                     o_rd_start,
    input  logic [AXI_DATA_WIDTH-1:0]                i_rd_data,
    input  logic                                     i_rd_done,
    input  logic                                     i_rd_fault
);

    localparam int unsigned BOB = byte_offset_bits(AXI_DATA_WIDTH);
    localparam int unsigned WOB = $clog2(WORDS_PER_LINE);
    localparam logic [AXI_ADDR_WIDTH-1:0] LINE_MASK =
        ~((AXI_ADDR_WIDTH'(1) << (BOB + WOB)) - AXI_ADDR_WIDTH'(1));
    localparam logic [AXI_ADDR_WIDTH-1:0] WORD_MASK =
        ~((AXI_ADDR_WIDTH'(1) << BOB) - AXI_ADDR_WIDTH'(1));
    localparam logic [WOB-1:0] LAST_CNT = WOB'(WORDS_PER_LINE - 1);

    t_fill_state    state;
    t_fill_state    next_state;
    logic [WOB-1:0] off;
    logic [WOB-1:0] next_off;
    logic [WOB-1:0] cnt;
    logic           fault;
    logic           accept;
    logic           rd_accept;
    logic           advance;

    assign next_off = off + WOB'(1);

    // Word offset within the line, loaded with the critical word on accept
    wrap_counter #(
        .WIDTH (WOB)
    ) u_off (
        .clk      (clk),
        .arst     (arst),
        .load     (accept),
        .load_val (i_fill_addr[BOB+WOB-1:BOB]),
        .inc      (advance),
        .count    (off)
    );

    // State register
    always_ff @(posedge clk) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and transition strobes
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        rd_accept  = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (i_fill_req) begin
                    accept     = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (i_rd_done) begin
                    rd_accept = 1'b1;
                    if (i_rd_fault || (cnt == LAST_CNT)) begin
                        next_state = DONE;
                    end else begin
                        advance    = 1'b1;
                        next_state = ISSUE;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs, derived from the upcoming state
    always_ff @(posedge clk) begin
        if (arst) begin
            cnt          <= '0;
            fault        <= 1'b0;
            o_fill_busy  <= 1'b0;
            o_fill_done  <= 1'b0;
            o_fill_fault <= 1'b0;
            o_line       <= '0;
            o_line_addr  <= '0;
            o_crit_valid <= 1'b0;
            o_crit_word  <= '0;
            o_rd_addr    <= '0;
            o_rd_start   <= 1'b0;
        end else begin
            o_rd_start   <= (next_state == ISSUE);
            o_fill_busy  <= (next_state != IDLE);
            o_fill_done  <= (next_state == DONE);
            o_fill_fault <= (next_state == DONE) && (fault || (rd_accept && i_rd_fault));
            o_crit_valid <= rd_accept && (cnt == '0);

            if (accept) begin
                o_line_addr <= i_fill_addr & LINE_MASK;
                o_rd_addr   <= i_fill_addr & WORD_MASK;
                cnt         <= '0;
                fault       <= 1'b0;
            end

            if (rd_accept) begin
                for (int i = 0; i < int'(WORDS_PER_LINE); i++) begin
                    if (off == WOB'(i)) begin
                        o_line[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rd_data;
                    end
                end
                if (cnt == '0) begin
                    o_crit_word <= i_rd_data;
                end
                if (i_rd_fault) begin
                    fault <= 1'b1;
                end
            end

            // Line base has zero low bits, so OR-ing in the offset forms the address
            if (advance) begin
                cnt       <= cnt + WOB'(1);
                o_rd_addr <= o_line_addr | (AXI_ADDR_WIDTH'(next_off) << BOB);
            end
        end
    end

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Directed self-checking bench for line_fill_ctrl with a behavioural read master.
module tb_line_fill_ctrl;

    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 32;
    localparam int unsigned WPL = 16;
    localparam int unsigned LW  = WPL * DW;

    logic          clk = 1'b0;
    logic          arst;
    logic          fill_req;
    logic [AW-1:0] fill_addr;
    logic          fill_busy;
    logic          fill_done;
    logic          fill_fault;
    logic [LW-1:0] line;
    logic [AW-1:0] line_addr;
    logic          crit_valid;
    logic [DW-1:0] crit_word;
    logic [AW-1:0] rd_addr;
    logic          rd_start;

    logic          resp_done;
    logic          resp_fault;
    logic [DW-1:0] resp_data;
    logic          man_done;
    logic          man_fault;
    logic [DW-1:0] man_data;
    logic          rd_done;
    logic          rd_fault;
    logic [DW-1:0] rd_data;

    assign rd_done  = resp_done | man_done;
    assign rd_fault = resp_fault | man_fault;
    assign rd_data  = man_done ? man_data : resp_data;

    int            resp_k   = 1;
    int            fault_at = 0;
    int            n_starts = 0;
    int            done_cnt = 0;
    logic [AW-1:0] start_q[$];
    logic [AW-1:0] resp_addr;

    int n_checks = 0;
    int n_pass   = 0;

    line_fill_ctrl #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .i_fill_req   (fill_req),
        .i_fill_addr  (fill_addr),
        .o_fill_busy  (fill_busy),
        .o_fill_done  (fill_done),
        .o_fill_fault (fill_fault),
        .o_line       (line),
        .o_line_addr  (line_addr),
        .o_crit_valid (crit_valid),
        .o_crit_word  (crit_word),
        .o_rd_addr    (rd_addr),
        .o_rd_start   (rd_start),
        .i_rd_data    (rd_data),
        .i_rd_done    (rd_done),
        .i_rd_fault   (rd_fault)
    );

    always #5 clk = ~clk;

    // Read master model: done arrives k cycles after start, data equals address
    always begin
        @(negedge clk);
        if (rd_start === 1'b1 && arst === 1'b0) begin
            resp_addr = rd_addr;
            start_q.push_back(resp_addr);
            n_starts++;
            @(posedge clk);
            repeat (resp_k - 1) @(posedge clk);
            #1;
            resp_data  = resp_addr[DW-1:0];
            resp_fault = (n_starts == fault_at);
            resp_done  = 1'b1;
            @(posedge clk);
            #1;
            resp_done  = 1'b0;
            resp_fault = 1'b0;
        end
    end

    // Count completion pulses
    always @(negedge clk) begin
        if (fill_done === 1'b1) done_cnt++;
    end

    task automatic do_req(input logic [AW-1:0] addr);
        @(posedge clk);
        #1;
        fill_req  = 1'b1;
        fill_addr = addr;
        @(posedge clk);
        #1;
        fill_req  = 1'b0;
    endtask

    // Called in cycle 'start'; returns cycle of fill_done and first crit_valid
    task automatic wait_done(input int start, output int cyc, output int crit_cyc);
        cyc      = start;
        crit_cyc = 0;
        while (fill_done !== 1'b1 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (crit_valid === 1'b1 && crit_cyc == 0) crit_cyc = cyc;
        end
    endtask

    task automatic test_reset();
        arst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;
        n_checks++; if (fill_busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", fill_busy); else n_pass++;
        n_checks++; if (fill_done !== 1'b0) $display("FAIL reset_done got %0b want 0", fill_done); else n_pass++;
        n_checks++; if (rd_start !== 1'b0) $display("FAIL reset_rd_start got %0b want 0", rd_start); else n_pass++;
        n_checks++; if (crit_valid !== 1'b0) $display("FAIL reset_crit_valid got %0b want 0", crit_valid); else n_pass++;
        n_checks++; if (line !== '0) $display("FAIL reset_line got nonzero want 0"); else n_pass++;
        n_checks++; if (line_addr !== '0) $display("FAIL reset_line_addr got %h want 0", line_addr); else n_pass++;
        n_checks++; if (rd_addr !== '0) $display("FAIL reset_rd_addr got %h want 0", rd_addr); else n_pass++;
        n_checks++; if (crit_word !== '0) $display("FAIL reset_crit_word got %h want 0", crit_word); else n_pass++;
    endtask

    task automatic test_fill_basic();
        int cyc, crit_cyc;
        resp_k = 1; n_starts = 0; start_q.delete();
        do_req(64'h1000);
        n_checks++; if (rd_start !== 1'b1) $display("FAIL basic_first_start got %0b want 1", rd_start); else n_pass++;
        n_checks++; if (rd_addr !== 64'h1000) $display("FAIL basic_first_addr got %h want 1000", rd_addr); else n_pass++;
        n_checks++; if (fill_busy !== 1'b1) $display("FAIL basic_busy got %0b want 1", fill_busy); else n_pass++;
        wait_done(1, cyc, crit_cyc);
        n_checks++; if (cyc != 33) $display("FAIL basic_done_cycle got %0d want 33", cyc); else n_pass++;
        n_checks++; if (fill_fault !== 1'b0) $display("FAIL basic_fault got %0b want 0", fill_fault); else n_pass++;
        n_checks++; if (n_starts != 16) $display("FAIL basic_starts got %0d want 16", n_starts); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (i >= start_q.size() || start_q[i] !== 64'(32'h1000 + 4 * i))
                $display("FAIL basic_start_addr[%0d] got %h want %h", i, (i < start_q.size()) ? start_q[i] : '0, 32'h1000 + 4 * i);
            else n_pass++;
            n_checks++;
            if (line[i*DW +: DW] !== 32'(32'h1000 + 4 * i))
                $display("FAIL basic_word[%0d] got %h want %h", i, line[i*DW +: DW], 32'h1000 + 4 * i);
            else n_pass++;
        end
        n_checks++; if (line_addr !== 64'h1000) $display("FAIL basic_line_addr got %h want 1000", line_addr); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc, crit_cyc;
        n_starts = 0; start_q.delete();
        fill_req  = 1'b1;
        fill_addr = 64'h7008;
        @(posedge clk);
        #1;
        n_checks++; if (rd_start !== 1'b0) $display("FAIL b2b_req_in_done got start %0b want 0", rd_start); else n_pass++;
        n_checks++; if (fill_busy !== 1'b0) $display("FAIL b2b_idle_busy got %0b want 0", fill_busy); else n_pass++;
        @(posedge clk);
        #1;
        fill_req = 1'b0;
        n_checks++; if (rd_start !== 1'b1) $display("FAIL b2b_start got %0b want 1", rd_start); else n_pass++;
        n_checks++; if (rd_addr !== 64'h7008) $display("FAIL b2b_addr got %h want 7008", rd_addr); else n_pass++;
        wait_done(1, cyc, crit_cyc);
        n_checks++; if (cyc != 33) $display("FAIL b2b_done_cycle got %0d want 33", cyc); else n_pass++;
        n_checks++; if (line_addr !== 64'h7000) $display("FAIL b2b_line_addr got %h want 7000", line_addr); else n_pass++;
        n_checks++; if (crit_word !== 32'h7008) $display("FAIL b2b_crit_word got %h want 7008", crit_word); else n_pass++;
        n_checks++; if (line[1*DW +: DW] !== 32'h7004) $display("FAIL b2b_word1 got %h want 7004", line[1*DW +: DW]); else n_pass++;
    endtask

    task automatic test_crit_first();
        int cyc, crit_cyc;
        n_starts = 0; start_q.delete();
        do_req(64'h1036);
        wait_done(1, cyc, crit_cyc);
        n_checks++; if (cyc != 33) $display("FAIL crit_done_cycle got %0d want 33", cyc); else n_pass++;
        n_checks++; if (crit_cyc != 3) $display("FAIL crit_valid_cycle got %0d want 3", crit_cyc); else n_pass++;
        n_checks++; if (crit_word !== 32'h1034) $display("FAIL crit_word got %h want 1034", crit_word); else n_pass++;
        n_checks++; if (line_addr !== 64'h1000) $display("FAIL crit_line_addr got %h want 1000", line_addr); else n_pass++;
        for (int j = 0; j < 16; j++) begin
            n_checks++;
            if (j >= start_q.size() || start_q[j] !== 64'(32'h1000 + 4 * ((13 + j) % 16)))
                $display("FAIL crit_order[%0d] got %h want %h", j, (j < start_q.size()) ? start_q[j] : '0, 32'h1000 + 4 * ((13 + j) % 16));
            else n_pass++;
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (line[i*DW +: DW] !== 32'(32'h1000 + 4 * i))
                $display("FAIL crit_word_idx[%0d] got %h want %h", i, line[i*DW +: DW], 32'h1000 + 4 * i);
            else n_pass++;
        end
    endtask

    task automatic test_fault();
        int cyc, crit_cyc;
        n_starts = 0; start_q.delete(); fault_at = 3;
        do_req(64'h3000);
        wait_done(1, cyc, crit_cyc);
        n_checks++; if (cyc != 7) $display("FAIL fault_done_cycle got %0d want 7", cyc); else n_pass++;
        n_checks++; if (fill_fault !== 1'b1) $display("FAIL fault_flag got %0b want 1", fill_fault); else n_pass++;
        repeat (6) @(posedge clk);
        #1;
        fault_at = 0;
        n_checks++; if (n_starts != 3) $display("FAIL fault_starts got %0d want 3", n_starts); else n_pass++;
        n_checks++; if (line[2*DW +: DW] !== 32'h3008) $display("FAIL fault_word2 got %h want 3008", line[2*DW +: DW]); else n_pass++;
        n_checks++; if (crit_word !== 32'h3000) $display("FAIL fault_crit got %h want 3000", crit_word); else n_pass++;
        n_checks++; if (fill_busy !== 1'b0) $display("FAIL fault_idle got %0b want 0", fill_busy); else n_pass++;
    endtask

    task automatic test_ignored_inputs();
        int cyc, crit_cyc, d0;
        n_starts = 0; start_q.delete();
        d0 = done_cnt;
        do_req(64'h4000);
        @(posedge clk);
        #1;
        fill_req  = 1'b1;
        fill_addr = 64'h9000;
        @(posedge clk);
        #1;
        fill_req = 1'b0;
        wait_done(3, cyc, crit_cyc);
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (cyc != 33) $display("FAIL ign_done_cycle got %0d want 33", cyc); else n_pass++;
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL ign_one_fill got %0d dones want 1", done_cnt - d0); else n_pass++;
        n_checks++; if (n_starts != 16) $display("FAIL ign_starts got %0d want 16", n_starts); else n_pass++;
        n_checks++; if (start_q.size() != 16 || start_q[15] !== 64'h403C) $display("FAIL ign_last_addr got size %0d want 403c last", start_q.size()); else n_pass++;
        // Stray read completion while idle
        d0 = done_cnt;
        man_data  = 32'hDEADBEEF;
        man_fault = 1'b1;
        man_done  = 1'b1;
        @(posedge clk);
        #1;
        man_done  = 1'b0;
        man_fault = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (fill_busy !== 1'b0) $display("FAIL idle_done_busy got %0b want 0", fill_busy); else n_pass++;
        n_checks++; if (line[0 +: DW] !== 32'h4000) $display("FAIL idle_done_word0 got %h want 4000", line[0 +: DW]); else n_pass++;
        n_checks++; if (crit_word !== 32'h4000) $display("FAIL idle_done_crit got %h want 4000", crit_word); else n_pass++;
        n_checks++; if (done_cnt != d0) $display("FAIL idle_done_pulse got %0d want %0d", done_cnt, d0); else n_pass++;
        n_checks++; if (n_starts != 16) $display("FAIL idle_done_starts got %0d want 16", n_starts); else n_pass++;
    endtask

    task automatic test_reset_midfill();
        int cyc, crit_cyc, d0;
        n_starts = 0; start_q.delete(); resp_k = 3;
        d0 = done_cnt;
        do_req(64'h5000);
        repeat (21) @(posedge clk);
        #1;
        arst = 1'b1;
        @(posedge clk);
        #1;
        arst = 1'b0;
        n_checks++; if (fill_busy !== 1'b0) $display("FAIL rstmid_busy got %0b want 0", fill_busy); else n_pass++;
        n_checks++; if (line_addr !== '0) $display("FAIL rstmid_line_addr got %h want 0", line_addr); else n_pass++;
        n_checks++; if (n_starts != 6) $display("FAIL rstmid_starts got %0d want 6", n_starts); else n_pass++;
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (done_cnt != d0) $display("FAIL rstmid_no_done got %0d want %0d", done_cnt, d0); else n_pass++;
        n_checks++; if (fill_busy !== 1'b0) $display("FAIL rstmid_stay_idle got %0b want 0", fill_busy); else n_pass++;
        resp_k = 1; n_starts = 0; start_q.delete();
        do_req(64'h2000);
        wait_done(1, cyc, crit_cyc);
        n_checks++; if (cyc != 33) $display("FAIL rstmid_refill_cycle got %0d want 33", cyc); else n_pass++;
        n_checks++; if (fill_fault !== 1'b0) $display("FAIL rstmid_refill_fault got %0b want 0", fill_fault); else n_pass++;
        n_checks++; if (line[5*DW +: DW] !== 32'h2014) $display("FAIL rstmid_refill_word5 got %h want 2014", line[5*DW +: DW]); else n_pass++;
    endtask

    task automatic test_latency();
        int cyc, crit_cyc;
        n_starts = 0; start_q.delete(); resp_k = 3;
        do_req(64'h6000);
        wait_done(1, cyc, crit_cyc);
        n_checks++; if (cyc != 65) $display("FAIL lat_done_cycle got %0d want 65", cyc); else n_pass++;
        n_checks++; if (crit_cyc != 5) $display("FAIL lat_crit_cycle got %0d want 5", crit_cyc); else n_pass++;
        n_checks++; if (fill_fault !== 1'b0) $display("FAIL lat_fault got %0b want 0", fill_fault); else n_pass++;
        n_checks++; if (line[0 +: DW] !== 32'h6000) $display("FAIL lat_word0 got %h want 6000", line[0 +: DW]); else n_pass++;
        n_checks++; if (line[15*DW +: DW] !== 32'h603C) $display("FAIL lat_word15 got %h want 603c", line[15*DW +: DW]); else n_pass++;
        resp_k = 1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        arst       = 1'b1;
        fill_req   = 1'b0;
        fill_addr  = '0;
        resp_done  = 1'b0;
        resp_fault = 1'b0;
        resp_data  = '0;
        man_done   = 1'b0;
        man_fault  = 1'b0;
        man_data   = '0;
        test_reset();
        test_fill_basic();
        test_back_to_back();
        test_crit_first();
        test_fault();
        test_ignored_inputs();
        test_reset_midfill();
        test_latency();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
